// File: rtl/mult32x32_pkg.sv
// Shared types and shift-select codes for the 32x32 multiplier controller and datapath.
package mult32x32_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A0B0,
    A0B1,
    A1B0,
    A1B1
  } mult_state_t;

  localparam logic [1:0] SHIFT_0  = 2'b00;
  localparam logic [1:0] SHIFT_16 = 2'b01;
  localparam logic [1:0] SHIFT_32 = 2'b10;

endpackage

// File: rtl/mult32x32_ctrl.sv
// Sequencer for the 16x16-multiplier datapath: clears the product on start,
// then walks four partial-product steps and flags completion on done.
module mult32x32_ctrl
  import mult32x32_pkg::*;
#(
  parameter int unsigned DONE_LEVEL = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       clr_prod,
  output logic       upd_prod,
  output logic       a_sel,
  output logic       b_sel,
  output logic [1:0] shift_sel
);

  mult_state_t state, state_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    clr_prod  = 1'b0;
    upd_prod  = 1'b0;
    a_sel     = 1'b0;
    b_sel     = 1'b0;
    shift_sel = SHIFT_0;
    unique case (state)
      IDLE: begin
        clr_prod  = start;
        state_nxt = start ? A0B0 : IDLE;
      end
      A0B0: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        state_nxt = A0B1;
      end
      A0B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        b_sel     = 1'b1;
        shift_sel = SHIFT_16;
        state_nxt = A1B0;
      end
      A1B0: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        shift_sel = SHIFT_16;
        state_nxt = A1B1;
      end
      A1B1: begin
        busy      = 1'b1;
        upd_prod  = 1'b1;
        a_sel     = 1'b1;
        b_sel     = 1'b1;
        shift_sel = SHIFT_32;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Level mode keeps done until the edge that accepts the next start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      done <= 1'b0;
    else if (state == A1B1)
      done <= 1'b1;
    else if ((DONE_LEVEL == 0) || ((state == IDLE) && start))
      done <= 1'b0;
  end

endmodule

// File: tb/tb_mult32x32_ctrl.sv
// Bench: controller plus a behavioural datapath, checked against a*b and the step table.
module tb_mult32x32_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done, clr_prod, upd_prod, a_sel, b_sel;
  logic [1:0]  shift_sel;
  logic        busy1, done1, clr_prod1, upd_prod1, a_sel1, b_sel1;
  logic [1:0]  shift_sel1;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mult32x32_ctrl #(.DONE_LEVEL(0)) u_dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .clr_prod(clr_prod), .upd_prod(upd_prod), .a_sel(a_sel), .b_sel(b_sel),
    .shift_sel(shift_sel)
  );

  mult32x32_ctrl #(.DONE_LEVEL(1)) u_dut_lvl (
    .clk(clk), .reset(reset), .start(start), .busy(busy1), .done(done1),
    .clr_prod(clr_prod1), .upd_prod(upd_prod1), .a_sel(a_sel1), .b_sel(b_sel1),
    .shift_sel(shift_sel1)
  );

  // Behavioural datapath: selected 16-bit halves, multiplied, shifted by 16*shift_sel.
  logic [63:0] pp;
  always_comb begin
    pp = 64'(a_sel ? a[31:16] : a[15:0]) * 64'(b_sel ? b[31:16] : b[15:0]);
    pp = pp << (16 * shift_sel);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         product <= '0;
    else if (clr_prod) product <= '0;
    else if (upd_prod) product <= product + pp;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One multiplication; pulse_k re-asserts start during that step, abort_k resets in that step.
  task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                        input int pulse_k, input int abort_k);
    logic [63:0] exp_p;
    logic        ea, eb;
    exp_p = 64'(av) * 64'(bv);
    a = av; b = bv; start = 1'b1;
    #1;
    check("clr_on_start", {clr_prod, busy}, {1'b1, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ea = (k >= 2);
      eb = (k % 2 == 1);
      if (k == abort_k) begin
        reset = 1'b1;
        #1;
        check("abort_flags", {busy, done, done1, upd_prod}, 4'b0000);
        check("abort_prod", product, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        return;
      end
      start = (k == pulse_k);
      #1;
      check("step_ctrl", {busy, upd_prod, clr_prod, done, done1},
            {1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
      check("step_sel", {a_sel, b_sel, shift_sel},
            {ea, eb, 2'(32'(ea) + 32'(eb))});
      @(posedge clk); #1;
      start = 1'b0;
    end
    check("done_cycle", {done, done1, busy, upd_prod}, 4'b1100);
    check("product", product, exp_p);
    @(posedge clk); #1;
    check("after_done", {done, done1, busy}, 3'b010);
    check("product_hold", product, exp_p);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      check("idle", {busy, done, done1, upd_prod, clr_prod, a_sel, b_sel, shift_sel}, '0);
      check("idle_prod", product, 64'd0);
      @(posedge clk); #1;
    end

    run_op(32'h0000_0003, 32'h0000_0005, -1, -1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
    check("max_const", product, 64'hFFFF_FFFE_0000_0001);

    for (int i = 0; i < 3; i++) begin
      check("level_hold", {done, done1}, 2'b01);
      @(posedge clk); #1;
    end

    for (int i = 0; i < 4; i++) run_op($urandom, $urandom, -1, -1);

    // Continuous start: accepted every 5 cycles, from IDLE only.
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; start = 1'b1;
    for (int t = 0; t < 15; t++) begin
      #1;
      if (t % 5 == 0) begin
        check("held_idle", {clr_prod, busy}, 2'b10);
        if (t > 0) begin
          check("held_done", {done, done1}, 2'b11);
          check("held_prod", product, 64'h0B00_EA4E_242D_2080);
        end
      end else begin
        check("held_step", {busy, clr_prod, done, shift_sel},
              {1'b1, 1'b0, 1'b0, 2'((t % 5 == 1) ? 0 : (t % 5 == 4) ? 2 : 1)});
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    #1;
    check("held_last_done", {done, busy, clr_prod}, 3'b100);
    check("held_last_prod", product, 64'h0B00_EA4E_242D_2080);
    @(posedge clk); #1;
    check("held_after", {done, done1, busy}, 3'b010);

    run_op(32'hDEAD_BEEF, 32'h0BAD_F00D, 1, -1);
    run_op($urandom, $urandom, 2, -1);

    run_op(32'hCAFE_1234, 32'h5678_9ABC, -1, 2);
    check("post_abort_idle", {busy, done, done1}, 3'b000);
    run_op($urandom, $urandom, -1, -1);
    run_op(32'h0001_0000, 32'h0001_0000, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
